// File: rtl/spi_resp_pkg.sv
// Shared types and command codes for the SPI memory responder.
package spi_resp_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, DISCARD} state_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser for sclk/cs_n/mosi plus sclk rise/fall detection.
module spi_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic rise,
  output logic fall
);

  // bit order {sclk, cs_n, mosi}
  logic [2:0] s1_q, s1_d, s2_q, s2_d;
  logic       prev_q, prev_d;

  always_comb begin
    s1_d   = {sclk, cs_n, mosi};
    s2_d   = s1_q;
    prev_d = s2_q[2];
  end

  // cs_n resets to "selected" so the responder cannot treat the first
  // synchroniser fill after reset as a frame boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign cs_n_s = s2_q[1];
  assign mosi_s = s2_q[0];
  assign rise   = s2_q[2] & ~prev_q;
  assign fall   = ~s2_q[2] & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave bridging a master to a single-port RAM (read/write bursts).
// Optional status command (0x05) enabled by defining SPI_RESP_STATUS_EN.
module spi_mem_responder
  import spi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  xfer_done
);

  logic cs_n_s, mosi_s, rise, fall;

  spi_sync_edge u_sync (
    .clock  (clock),
    .reset  (reset),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .cs_n_s (cs_n_s),
    .mosi_s (mosi_s),
    .rise   (rise),
    .fall   (fall)
  );

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rd_q, rd_d;
  logic                  armed_q, armed_d;
  logic [1:0]            ld_pipe_q, ld_pipe_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] newbits, load_word, cur_word;

`ifdef SPI_RESP_STATUS_EN
  logic        stat_q, stat_d;
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  assign load_word = stat_q ? DATA_WIDTH'({wr_cnt_q, rd_cnt_q}) : ram_rdata;
`else
  assign load_word = ram_rdata;
`endif

  assign newbits = {shift_q[DATA_WIDTH-2:0], mosi_s};
  // ld_pipe[1] marks the clock in which the fetched word is valid; bypass it
  // so a fall landing in that same clock still sees the new MSB.
  assign cur_word = ld_pipe_q[1] ? load_word : shift_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    armed_d   = armed_q;
    ld_pipe_d = {ld_pipe_q[0], 1'b0};
    miso_d    = miso_q;
    oe_d      = oe_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
`ifdef SPI_RESP_STATUS_EN
    stat_d    = stat_q;
    wr_cnt_d  = we_q ? sat_inc16(wr_cnt_q) : wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
`endif

    // Post-write increment runs regardless of cs_n so a scheduled write completes.
    if (we_q) addr_d = addr_q + ADDR_WIDTH'(1);

    if (cs_n_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      armed_d = 1'b1;
`ifdef SPI_RESP_STATUS_EN
      stat_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (armed_q) state_d = CMD;
        end
        CMD: if (rise) begin
          shift_d = newbits;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d = '0;
            case (newbits[7:0])
              CMD_READ:   begin state_d = ADDR; rd_d = 1'b1; end
              CMD_WRITE:  begin state_d = ADDR; rd_d = 1'b0; end
`ifdef SPI_RESP_STATUS_EN
              CMD_STATUS: begin
                state_d      = RD_DATA;
                stat_d       = 1'b1;
                ld_pipe_d[0] = 1'b1;
              end
`endif
              default:    state_d = DISCARD;
            endcase
          end
        end
        ADDR: if (rise) begin
          shift_d = newbits;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'(ADDR_WIDTH-1)) begin
            cnt_d  = '0;
            addr_d = newbits[ADDR_WIDTH-1:0];
            if (rd_q) begin
              state_d      = RD_DATA;
              ld_pipe_d[0] = 1'b1;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          shift_d = cur_word;
          if (fall) begin
            oe_d    = 1'b1;
            miso_d  = cur_word[DATA_WIDTH-1];
            shift_d = {cur_word[DATA_WIDTH-2:0], 1'b0};
          end
          if (rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(DATA_WIDTH-1)) begin
              cnt_d        = '0;
              done_d       = 1'b1;
              ld_pipe_d[0] = 1'b1;
`ifdef SPI_RESP_STATUS_EN
              if (!stat_q) begin
                addr_d   = addr_q + ADDR_WIDTH'(1);
                rd_cnt_d = sat_inc16(rd_cnt_q);
              end
`else
              addr_d = addr_q + ADDR_WIDTH'(1);
`endif
            end
          end
        end
        WR_DATA: if (rise) begin
          shift_d = newbits;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'(DATA_WIDTH-1)) begin
            cnt_d   = '0;
            wdata_d = newbits;
            we_d    = 1'b1;
            done_d  = 1'b1;
          end
        end
        DISCARD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      rd_q      <= 1'b0;
      armed_q   <= 1'b0;
      ld_pipe_q <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      armed_q   <= armed_d;
      ld_pipe_q <= ld_pipe_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
    end
  end

`ifdef SPI_RESP_STATUS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      stat_q   <= stat_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
`endif

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_wdata = wdata_q;
  assign xfer_done = done_q;

endmodule
